// File: rtl/decode_scoreboard.sv
// Register-hazard scoreboard for decode: per-register pending-write counters gate issue.
// Latency: issue/stall are combinational from current counts; busy/err/stall_cycles update on the next edge.
// Backpressure: stalls on a source hazard, on a full destination counter, or when execute is not ready.
module decode_scoreboard #(
    parameter int NREG  = 8,
    parameter int SELW  = 3,
    parameter int CNTW  = 2,
    parameter int PERFW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [SELW-1:0]  id_rs_sel,
    input  logic             id_rs_use,
    input  logic [SELW-1:0]  id_rt_sel,
    input  logic             id_rt_use,
    input  logic [SELW-1:0]  id_wr_sel,
    input  logic             id_wr_en,
    input  logic             ex_ready,
    input  logic             wb_valid,
    input  logic [SELW-1:0]  wb_sel,
    input  logic             sq_valid,
    input  logic [SELW-1:0]  sq_sel,
    output logic             issue,
    output logic             stall,
    output logic [NREG-1:0]  busy,
    output logic [PERFW-1:0] stall_cycles,
    output logic             err
);

    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [CNTW:0]   CNT_MAXW = {1'b0, CNT_MAX};

    logic [CNTW-1:0] cnt      [NREG];
    logic [CNTW-1:0] cnt_next [NREG];
    logic [CNTW-1:0] rs_eff;
    logic [CNTW-1:0] rt_eff;
    logic            hazard;
    logic            full;
    logic            bad_update;

    // Source readiness with writeback bypass: a commit this cycle already satisfies the read.
    always_comb begin
        rs_eff = cnt[id_rs_sel];
        if (wb_valid && (wb_sel == id_rs_sel) && (cnt[id_rs_sel] != '0)) begin
            rs_eff = cnt[id_rs_sel] - 1'b1;
        end
        rt_eff = cnt[id_rt_sel];
        if (wb_valid && (wb_sel == id_rt_sel) && (cnt[id_rt_sel] != '0)) begin
            rt_eff = cnt[id_rt_sel] - 1'b1;
        end
        hazard = (id_rs_use && (rs_eff != '0)) || (id_rt_use && (rt_eff != '0));
        // Capacity uses the raw count: a same-cycle writeback does not free a slot for this issue.
        full   = id_wr_en && (cnt[id_wr_sel] == CNT_MAX);
        issue  = id_valid && ex_ready && !hazard && !full;
        stall  = id_valid && !issue;
    end

    // Next pending counts; underflow clamps to zero, overflow clamps to max, both flag an error.
    always_comb begin
        bad_update = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            logic [CNTW:0] sum;
            logic [CNTW:0] dec;
            logic          inc;
            logic          wb_hit;
            logic          sq_hit;
            inc    = issue && id_wr_en && (id_wr_sel == SELW'(r));
            wb_hit = wb_valid && (wb_sel == SELW'(r));
            sq_hit = sq_valid && (sq_sel == SELW'(r));
            sum    = {1'b0, cnt[r]} + {{CNTW{1'b0}}, inc};
            dec    = {{CNTW{1'b0}}, wb_hit} + {{CNTW{1'b0}}, sq_hit};
            cnt_next[r] = cnt[r];
            if (dec > sum) begin
                cnt_next[r] = '0;
                bad_update  = 1'b1;
            end else if ((sum - dec) > CNT_MAXW) begin
                cnt_next[r] = CNT_MAX;
                bad_update  = 1'b1;
            end else begin
                cnt_next[r] = CNTW'(sum - dec);
            end
        end
    end

    // State registers: counters, busy mirror of the new counts, perf counter, error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            busy         <= '0;
            stall_cycles <= '0;
            err          <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r]  <= cnt_next[r];
                busy[r] <= (cnt_next[r] != '0);
            end
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            err <= bad_update;
        end
    end

endmodule

// File: tb/tb_decode_scoreboard.sv
module tb_decode_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [2:0]  id_rs_sel;
    logic        id_rs_use;
    logic [2:0]  id_rt_sel;
    logic        id_rt_use;
    logic [2:0]  id_wr_sel;
    logic        id_wr_en;
    logic        ex_ready;
    logic        wb_valid;
    logic [2:0]  wb_sel;
    logic        sq_valid;
    logic [2:0]  sq_sel;
    logic        issue;
    logic        stall;
    logic [7:0]  busy;
    logic [15:0] stall_cycles;
    logic        err;

    int total = 0;
    int bad   = 0;

    decode_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs_sel    (id_rs_sel),
        .id_rs_use    (id_rs_use),
        .id_rt_sel    (id_rt_sel),
        .id_rt_use    (id_rt_use),
        .id_wr_sel    (id_wr_sel),
        .id_wr_en     (id_wr_en),
        .ex_ready     (ex_ready),
        .wb_valid     (wb_valid),
        .wb_sel       (wb_sel),
        .sq_valid     (sq_valid),
        .sq_sel       (sq_sel),
        .issue        (issue),
        .stall        (stall),
        .busy         (busy),
        .stall_cycles (stall_cycles),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs_sel = 0; id_rs_use = 0; id_rt_sel = 0; id_rt_use = 0;
        id_wr_sel = 0; id_wr_en = 0; ex_ready = 1; wb_valid = 0; wb_sel = 0;
        sq_valid = 0; sq_sel = 0;
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_only(input logic [2:0] r);
        idle();
        id_valid = 1; id_wr_en = 1; id_wr_sel = r;
    endtask

    task automatic read_rs(input logic [2:0] r);
        idle();
        id_valid = 1; id_rs_use = 1; id_rs_sel = r;
    endtask

    initial begin
        idle();
        rst = 0;
        tick();
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_perf", 32'(stall_cycles), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        rst = 1;

        // ADD r3: no hazard, issues and marks r3 pending
        write_only(3'd3);
        #1 chk("add_r3_issue", 32'(issue), 32'h1);
        chk("add_r3_nostall", 32'(stall), 32'h0);
        tick();
        chk("busy_r3", 32'(busy), 32'h08);

        // reader of r3 stalls two cycles
        read_rs(3'd3);
        #1 chk("raw_r3_stall", 32'(stall), 32'h1);
        chk("raw_r3_noissue", 32'(issue), 32'h0);
        tick();
        chk("perf_1", 32'(stall_cycles), 32'h1);
        tick();
        chk("perf_2", 32'(stall_cycles), 32'h2);

        // same-cycle writeback of r3 bypasses the hazard
        wb_valid = 1; wb_sel = 3'd3;
        #1 chk("wb_bypass_issue", 32'(issue), 32'h1);
        tick();
        chk("wb_bypass_busy", 32'(busy), 32'h0);
        chk("perf_hold", 32'(stall_cycles), 32'h2);

        // rt port hazard uses the same bypass-less path when no writeback
        write_only(3'd7);
        tick();
        idle();
        id_valid = 1; id_rt_use = 1; id_rt_sel = 3'd7;
        #1 chk("rt_hazard_stall", 32'(stall), 32'h1);
        tick();
        idle();
        wb_valid = 1; wb_sel = 3'd7;
        tick();
        chk("r7_drained", 32'(busy), 32'h0);

        // execute not ready stalls a hazard-free instruction
        write_only(3'd0);
        ex_ready = 0;
        #1 chk("exrdy_stall", 32'(stall), 32'h1);
        chk("exrdy_noissue", 32'(issue), 32'h0);
        tick();
        chk("exrdy_perf", 32'(stall_cycles), 32'h4);
        chk("exrdy_no_busy", 32'(busy), 32'h0);

        // three writers to r5 fill the counter; the fourth is blocked
        for (int i = 0; i < 3; i++) begin
            write_only(3'd5);
            #1 chk("r5_fill_issue", 32'(issue), 32'h1);
            tick();
        end
        chk("r5_busy", 32'(busy), 32'h20);
        write_only(3'd5);
        #1 chk("r5_full_stall", 32'(stall), 32'h1);
        tick();
        wb_valid = 1; wb_sel = 3'd5;
        #1 chk("r5_full_wb_stall", 32'(stall), 32'h1);
        tick();
        wb_valid = 0;
        #1 chk("r5_after_wb_issue", 32'(issue), 32'h1);
        tick();
        chk("r5_err_none", 32'(err), 32'h0);
        idle();
        wb_valid = 1; wb_sel = 3'd5;
        tick();
        tick();
        chk("r5_one_left", 32'(busy), 32'h20);
        tick();
        chk("r5_empty", 32'(busy), 32'h0);
        chk("r5_noerr", 32'(err), 32'h0);

        // writeback + squash of r2 with count 1 underflows
        write_only(3'd2);
        tick();
        idle();
        wb_valid = 1; wb_sel = 3'd2; sq_valid = 1; sq_sel = 3'd2;
        tick();
        chk("udf_err", 32'(err), 32'h1);
        chk("udf_busy", 32'(busy), 32'h0);
        idle();
        tick();
        chk("udf_err_pulse", 32'(err), 32'h0);
        read_rs(3'd2);
        #1 chk("udf_cnt_zero", 32'(issue), 32'h1);
        tick();

        // ADDI r1,r1: source checked before own increment; repeat then stalls
        idle();
        id_valid = 1; id_rs_use = 1; id_rs_sel = 3'd1; id_wr_en = 1; id_wr_sel = 3'd1;
        #1 chk("self_dep_issue", 32'(issue), 32'h1);
        tick();
        #1 chk("self_dep_stall", 32'(stall), 32'h1);
        idle();
        wb_valid = 1; wb_sel = 3'd1;
        tick();

        // issue to r4 with same-cycle writeback of r4 keeps count at 1
        write_only(3'd4);
        tick();
        wb_valid = 1; wb_sel = 3'd4;
        #1 chk("r4_net_issue", 32'(issue), 32'h1);
        tick();
        chk("r4_net_busy", 32'(busy), 32'h10);
        idle();
        wb_valid = 1; wb_sel = 3'd4;
        tick();
        chk("r4_net_one", 32'(busy), 32'h0);
        chk("r4_net_noerr", 32'(err), 32'h0);

        // reset mid-stall with two pending writes to r6
        write_only(3'd6);
        tick();
        tick();
        chk("r6_busy", 32'(busy), 32'h40);
        read_rs(3'd6);
        #1 chk("r6_stall", 32'(stall), 32'h1);
        rst = 0;
        tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_perf", 32'(stall_cycles), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1;
        #1 chk("rst_r6_issue", 32'(issue), 32'h1);
        chk("rst_r6_nostall", 32'(stall), 32'h0);
        tick();
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
